// File: rtl/divrem_arb_pkg.sv
// Shared types and defaults for the divrem arbiter/sequencer.
package divrem_arb_pkg;
  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    RESP
  } state_t;
endpackage

// File: rtl/divrem_arb_rr_pick.sv
// Combinational round-robin selector: first asserted req scanning from ptr upward, wrapping at NREQ.
module divrem_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx
);
  // Scan farthest-first so the candidate closest to ptr is written last and wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/divrem_arb.sv
// Shares one divrem unit among NREQ requesters: round-robin grant, go handshake,
// completion tracking with a hang timeout, and result return to the owner.
module divrem_arb
  import divrem_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NREQ    = 2,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_num,
  input  logic [NREQ*W-1:0] req_den,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_quot,
  output logic [W-1:0]      resp_rem,
  output logic              resp_error,
  output logic              resp_timeout,
  output logic              busy,
  output logic              div_go,
  output logic [W-1:0]      div_num,
  output logic [W-1:0]      div_den,
  input  logic              div_ready,
  input  logic              div_error,
  input  logic [W-1:0]      div_quot,
  input  logic [W-1:0]      div_rem
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, owner;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           tmo_hit;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_idx;

  divrem_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign busy = (state != IDLE);

  // Timeout fires on the edge where the wait counter would reach TIMEOUT-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    tmo_hit   = (cnt_nxt == CW'(TIMEOUT - 1));
    case (state)
      IDLE:      if (div_ready && gnt_valid) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!div_ready) state_nxt = WAIT_DONE;
                 else if (tmo_hit) state_nxt = RESP;
      WAIT_DONE: if (div_ready || tmo_hit) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      req_ack      <= '0;
      resp_valid   <= '0;
      resp_quot    <= '0;
      resp_rem     <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
      div_go       <= 1'b0;
      div_num      <= '0;
      div_den      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (state_nxt == ISSUE) begin
          owner   <= gnt_idx;
          div_num <= req_num[int'(gnt_idx)*W +: W];
          div_den <= req_den[int'(gnt_idx)*W +: W];
          div_go  <= 1'b1;
          req_ack <= NREQ'(1) << gnt_idx;
        end
        ISSUE: begin
          div_go  <= 1'b0;
          req_ack <= '0;
          cnt     <= '0;
        end
        WAIT_LOW, WAIT_DONE: begin
          cnt <= cnt_nxt;
          if (state_nxt == RESP) begin
            resp_valid <= NREQ'(1) << owner;
            // Real completion wins over a coincident timeout.
            if (state == WAIT_DONE && div_ready) begin
              resp_quot    <= div_quot;
              resp_rem     <= div_rem;
              resp_error   <= div_error;
              resp_timeout <= 1'b0;
            end else begin
              resp_quot    <= '0;
              resp_rem     <= '0;
              resp_error   <= 1'b1;
              resp_timeout <= 1'b1;
            end
          end
        end
        RESP: begin
          resp_valid <= '0;
          ptr        <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divrem_arb.sv
// Randomized directed bench for divrem_arb with a behavioural divrem stand-in.
module tb_divrem_arb;
  localparam int W       = 16;
  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int TIMEOUT = 8;
  localparam int BOUND   = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_num, req_den;
  logic [NREQ-1:0]   req_ack, resp_valid;
  logic [W-1:0]      resp_quot, resp_rem;
  logic              resp_error, resp_timeout, busy;
  logic              div_go, div_ready, div_error;
  logic [W-1:0]      div_num, div_den, div_quot, div_rem;

  int tests = 0;
  int fails = 0;

  bit         tv[NREQ];
  logic [W-1:0] tn[NREQ], td[NREQ];
  int         ptr_m;
  bit         stuck;
  int         lat;

  always #5 clk = ~clk;

  divrem_arb #(.W(W), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ack(req_ack), .resp_valid(resp_valid),
    .resp_quot(resp_quot), .resp_rem(resp_rem),
    .resp_error(resp_error), .resp_timeout(resp_timeout), .busy(busy),
    .div_go(div_go), .div_num(div_num), .div_den(div_den),
    .div_ready(div_ready), .div_error(div_error),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  // divrem stand-in: ready low for 'lat' cycles after an accepted go; 'stuck' ignores go entirely.
  logic [W-1:0] m_num, m_den;
  int           m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      div_ready <= 1'b1;
      div_error <= 1'b0;
      div_quot  <= '0;
      div_rem   <= '0;
      m_cnt     <= 0;
    end else if (div_ready) begin
      if (div_go && !stuck) begin
        div_ready <= 1'b0;
        m_num     <= div_num;
        m_den     <= div_den;
        m_cnt     <= lat;
      end
    end else if (m_cnt <= 1) begin
      div_ready <= 1'b1;
      div_error <= (m_den == '0);
      div_quot  <= (m_den == '0) ? '1 : m_num / m_den;
      div_rem   <= (m_den == '0) ? m_num : m_num % m_den;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = tv[i];
      req_num[i*W +: W]  = tn[i];
      req_den[i*W +: W]  = td[i];
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
    tv[i] = 1'b1;
    tn[i] = n;
    td[i] = d;
    drive();
  endtask

  function automatic int rr_ref();
    for (int k = 0; k < NREQ; k++)
      if (tv[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return 0;
  endfunction

  // One full transaction: expected owner from the round-robin rule, result from plain arithmetic.
  task automatic run_one(input bit tmo_exp, output int own);
    int n;
    logic [W-1:0] eq, er;
    bit ee, et;
    own = rr_ref();
    n = 0;
    while (req_ack == '0 && n < BOUND) begin @(negedge clk); n++; end
    check("ack_seen", 64'(n < BOUND), 1);
    check("ack_owner", 64'(req_ack), 64'(NREQ'(1) << own));
    check("go_with_ack", 64'(div_go), 1);
    check("busy", 64'(busy), 1);
    check("div_num", 64'(div_num), 64'(tn[own]));
    check("div_den", 64'(div_den), 64'(td[own]));
    tv[own] = 1'b0;
    drive();
    @(negedge clk);
    check("ack_go_pulse", 64'({req_ack, div_go}), 0);
    n = 1;
    while (resp_valid == '0 && n < BOUND) begin @(negedge clk); n++; end
    check("resp_seen", 64'(n < BOUND), 1);
    if (tmo_exp) begin
      eq = '0; er = '0; ee = 1'b1; et = 1'b1;
    end else if (td[own] == '0) begin
      eq = '1; er = tn[own]; ee = 1'b1; et = 1'b0;
    end else begin
      eq = tn[own] / td[own]; er = tn[own] % td[own]; ee = 1'b0; et = 1'b0;
    end
    check("resp_owner", 64'(resp_valid), 64'(NREQ'(1) << own));
    check("resp_quot", 64'(resp_quot), 64'(eq));
    check("resp_rem", 64'(resp_rem), 64'(er));
    check("resp_error", 64'(resp_error), 64'(ee));
    check("resp_timeout", 64'(resp_timeout), 64'(et));
    if (tmo_exp) check("tmo_latency", 64'(n), 64'(TIMEOUT));
    @(negedge clk);
    check("resp_pulse", 64'(resp_valid), 0);
    check("resp_hold", 64'(resp_quot), 64'(eq));
    ptr_m = (own + 1) % NREQ;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({req_ack, resp_valid, busy, div_go, resp_error, resp_timeout}), 0);
    check({tag, "_div"}, 64'({div_num, div_den}), 0);
    check({tag, "_res"}, 64'({resp_quot, resp_rem}), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int own;
    int n;
    for (int i = 0; i < NREQ; i++) begin tv[i] = 1'b0; tn[i] = '0; td[i] = '0; end
    drive();
    stuck = 1'b0;
    lat   = 2;
    ptr_m = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // single request 17/5
    set_req(0, 16'd17, 16'd5);
    run_one(1'b0, own);

    // simultaneous requests right after reset: 0 first, then 1
    pulse_reset();
    lat = $urandom_range(1, 4);
    tv[0] = 1'b1; tn[0] = 16'd100; td[0] = 16'd7;
    tv[1] = 1'b1; tn[1] = 16'd9;   td[1] = 16'd3;
    drive();
    run_one(1'b0, own);
    check("pair_first", 64'(own), 0);
    lat = $urandom_range(1, 4);
    run_one(1'b0, own);
    check("pair_second", 64'(own), 1);

    // both requesters keep re-requesting: strict alternation
    set_req(0, 16'($urandom), 16'($urandom_range(1, 300)));
    set_req(1, 16'($urandom), 16'($urandom_range(1, 300)));
    for (int k = 0; k < 4; k++) begin
      lat = $urandom_range(1, 4);
      run_one(1'b0, own);
      check("rr_order", 64'(own), 64'(k % 2));
      set_req(own, 16'($urandom), 16'($urandom_range(1, 300)));
    end
    // drain the outstanding requests so only the intended ones remain
    for (int k = 0; k < NREQ; k++) run_one(1'b0, own);

    // divide by zero from requester 1
    set_req(1, 16'd12, 16'd0);
    run_one(1'b0, own);

    // hung divider: forced error response after TIMEOUT cycles, then normal service
    stuck = 1'b1;
    set_req(0, 16'($urandom), 16'($urandom_range(1, 300)));
    run_one(1'b1, own);
    stuck = 1'b0;
    set_req(1, 16'($urandom), 16'($urandom_range(1, 300)));
    run_one(1'b0, own);

    // reset while requester 1 is waiting on the divider
    lat = 4;
    set_req(1, 16'($urandom), 16'($urandom_range(1, 300)));
    n = 0;
    while (req_ack == '0 && n < BOUND) begin @(negedge clk); n++; end
    check("rst_ack", 64'(req_ack), 2'b10);
    repeat (2) @(negedge clk);
    check("rst_in_wait", 64'({busy, div_ready}), 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    ptr_m = 0;
    lat = $urandom_range(1, 4);
    run_one(1'b0, own);
    check("rst_regrant", 64'(own), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
